// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Deserializes the UART frames of the transmit path back into parallel words.
// The frame is: start bit (0), WIDTH data bits LSB first, an optional even-
// parity bit, and a stop bit (1). Bit timing comes from a cycle counter running
// at CLKS_PER_BIT clocks per bit. Every bit is sampled once, near its middle.
// There is no oversampling voter and no FIFO. A received word is flagged for
// exactly one cycle.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   - the frame carries an even-parity bit before the stop bit.
//               A mismatch pulses parity_err in place of rx_valid.
//   undefined - plain 10-bit frames. parity_err is tied to 0.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 3)
//   WIDTH         data bits per frame
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_in       serial line, idle high, asynchronous to clk
//   rx_data     last correctly received word (held between frames)
//   rx_valid    one-cycle pulse: rx_data has just been updated
//   frame_err   one-cycle pulse: the stop bit was sampled low
//   parity_err  one-cycle pulse: parity mismatch (0 without parity)
//   rx_busy     high while a frame is in progress, including a line break
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 3,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // The start bit is confirmed HALF cycles after the falling edge is seen.
    // After that, every bit is sampled a whole bit period after the previous one.
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Input synchronizer. It resets to idle-high, so leaving reset never
    // looks like a start bit.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             busy_q;
    logic             bit_tick;
`ifdef UART_RX_PARITY_EN
    logic             par_q;
    logic             perr_q;
`endif

    assign cnt_d    = cnt_q + CW'(1);
    assign bit_tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            // By default the status pulses last only one cycle.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end else begin
                            // The line went back high before the middle of the
                            // start bit. Treat it as a glitch and drop it silently.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_DATA: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        // LSB arrives first. Each new bit enters at the top and
                        // works its way down to bit 0.
                        shift_q <= {rx_s, shift_q[WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Go back to idle at mid-stop-bit. This way a start
                            // bit right after the stop bit is still caught.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data bits plus the parity bit must XOR to 0.
                            if (^{shift_q, par_q}) begin
                                perr_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_WAIT_HIGH: begin
                    // Stay busy during a break, so a line held low can never
                    // be mistaken for a run of frames.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserializes the 10-bit frames produced by the UART transmit path (start bit 0, WIDTH data bits LSB first, stop bit 1) back into parallel bytes. It sits directly downstream of the transmitter's serial output and is the consumer stage in loopback tests of the ROM-driven transmitter. Bit timing uses a cycle counter at CLKS_PER_BIT clocks per bit with mid-bit sampling. It has no oversampling voter and no FIFO; each received word is presented for one cycle.

## Interface
- CLKS_PER_BIT, 3, clocks per serial bit; legal range ≥ 3
- WIDTH, 8, data bits per frame
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_in  in  1  serial line, idle high; asynchronous to clk
- rx_data  out  WIDTH  last correctly received word
- rx_valid  out  1  one-cycle pulse: rx_data just updated
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 unless parity enabled)
- rx_busy  out  1  high while a frame is being received

## Operation
- rx_in passes through a 2-flop synchronizer whose flops reset to 1. The internal signal rx_s(t) = rx_in(t-2).
- HALF = (CLKS_PER_BIT-1)/2 (integer). The bit counter width is $clog2(WIDTH), and the cycle counter width is $clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, PARITY (parity builds only), STOP, WAIT_HIGH.
- IDLE: when rx_s=0, go to START, clear the cycle counter, and set rx_busy.
- START: at cycle count HALF, sample rx_s.
  - If rx_s=0, go to DATA with the cycle counter cleared.
  - If rx_s=1, treat it as a glitch: return to IDLE, clear rx_busy, and assert no pulse.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register. Bits arrive LSB first. After WIDTH samples, go to STOP (or PARITY).
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If rx_s=1 (and no parity error): load rx_data from the shift register, pulse rx_valid, and go to IDLE.
  - If rx_s=0: pulse frame_err, leave rx_data unchanged, and go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. rx_busy stays high in this state, so a break condition never produces frames.
- rx_data holds its value between frames and changes only together with rx_valid.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, rx_busy=0, state=IDLE, synchronizer=1'b1.
- Let t be the cycle in which IDLE sees rx_s=0. Sample points:
  - start bit at t+1+HALF
  - data bit k at t+1+HALF+(k+1)·CLKS_PER_BIT
  - stop bit at t+1+HALF+(WIDTH+1)·CLKS_PER_BIT; add CLKS_PER_BIT when parity is enabled
- rx_valid, frame_err and parity_err are registered. Each is high for exactly one cycle, in the cycle after the stop sample.
- Returning to IDLE at mid-stop-bit lets a new start bit that immediately follows the stop bit be caught. Back-to-back frames with zero idle gap are received without loss.
- rx_valid, frame_err and parity_err are mutually exclusive.
- Reset asserted mid-frame: on the next edge everything returns to reset values, and no pulse is produced for the partial frame.
- rx_in changes between sample points are ignored. Only the mid-bit sample counts.

## Configuration
- UART_RX_PARITY_EN
  - Defined: the frame carries an even-parity bit between the last data bit and the stop bit, and the PARITY state samples it after CLKS_PER_BIT cycles. At the stop sample, when the stop bit is high but parity mismatches, parity_err pulses in place of rx_valid and rx_data is not updated. A stop bit sampled low gives frame_err only.
  - Undefined: 10-bit frames, no PARITY state, parity_err tied 0.

## Test plan
- CLKS_PER_BIT=3; drive frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → rx_valid pulses once, rx_data=8'hA5, at the cycle given in Timing.
- Frames 0x00 then 0xFF back-to-back with no idle gap → two rx_valid pulses 10·CLKS_PER_BIT cycles apart; rx_data reads 8'h00 and then 8'hFF.
- rx_in low for 1 cycle, then high → no pulse; rx_busy high for HALF+1 cycles, then 0.
- Frame 0x3C with the stop bit driven 0, line held low 30 cycles, then high → frame_err pulses once and rx_data keeps its previous value. No pulse occurs and rx_busy stays high until the line is back high.
- rst asserted in the middle of data bit 4 of a frame → next cycle all outputs are at reset values and no pulse follows. A subsequent frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: frame 0x07 with parity bit 1 → rx_valid and rx_data=8'h07. The same frame with parity bit 0 → parity_err pulses and rx_data is unchanged.
